// File: rtl/ahb_mtx_cmd_master.sv
// AHB initiator for a bus-matrix slave port: turns a valid/ready command stream into
// single NONSEQ transfers with pipelined address/data phases, two-cycle responses and replay.
module ahb_mtx_cmd_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_RETRY = 15
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic          cmd_write,
    input  logic [2:0]    cmd_size,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          busy,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic [1:0]    HRESP,
    input  logic [DW-1:0] HRDATA
);
    localparam int CW = $clog2(MAX_RETRY + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [2:0]    size;
        logic [DW-1:0] wdata;
        logic [CW-1:0] cnt;
    } xfer_t;

    xfer_t a_q, d_q, r_q, new_x, d_rty;
    logic  a_vld, d_vld, r_vld, cancel, rdy_en;
    logic  accept, resp_ok, resp_error, done_ok, second, first, retry_ok;

    always_comb begin
        new_x       = '0;
        new_x.addr  = cmd_addr;
        new_x.write = cmd_write;
        new_x.size  = cmd_size;
        new_x.wdata = cmd_wdata;
        d_rty       = d_q;
        d_rty.cnt   = d_q.cnt + CW'(1);
    end

    assign resp_ok    = (HRESP == 2'b00);
    assign resp_error = (HRESP == 2'b01);
    assign done_ok    = HREADY & resp_ok;
    assign second     = HREADY & ~resp_ok;
    assign first      = ~HREADY & ~resp_ok & d_vld;
    assign retry_ok   = second & d_vld & ~resp_error & (d_q.cnt < CW'(MAX_RETRY));

    // rdy_en keeps the port closed while reset is held and for the release edge
    assign cmd_ready = rdy_en & ~r_vld & ~cancel & (~a_vld | HREADY);
    assign accept    = cmd_valid & cmd_ready;

    assign HADDR  = a_q.addr;
    assign HWRITE = a_q.write;
    assign HSIZE  = a_q.size;
    assign HTRANS = (a_vld & ~cancel) ? 2'b10 : 2'b00;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;
    assign HWDATA = d_q.wdata;
    assign busy   = a_vld | d_vld | r_vld;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            a_vld     <= 1'b0;
            d_vld     <= 1'b0;
            r_vld     <= 1'b0;
            cancel    <= 1'b0;
            rdy_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rdy_en    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (first)
                cancel <= 1'b1;
            else if (HREADY)
                cancel <= 1'b0;

            if (done_ok) begin
                if (d_vld) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= d_q.write ? '0 : HRDATA;
                end
                // a cancelled A never reached the bus, so it cannot advance
                d_vld <= a_vld & ~cancel;
                if (a_vld & ~cancel)
                    d_q <= a_q;
                if (~cancel | ~a_vld) begin
                    if (r_vld) begin
                        a_q   <= r_q;
                        a_vld <= 1'b1;
                        r_vld <= 1'b0;
                    end else if (accept) begin
                        a_q   <= new_x;
                        a_vld <= 1'b1;
                    end else begin
                        a_vld <= 1'b0;
                    end
                end
            end else if (second) begin
                d_vld <= 1'b0;
                if (retry_ok) begin
                    // replay D ahead of whatever was waiting in A
                    a_q   <= d_rty;
                    a_vld <= 1'b1;
                    if (a_vld) begin
                        r_q   <= a_q;
                        r_vld <= 1'b1;
                    end else if (accept) begin
                        r_q   <= new_x;
                        r_vld <= 1'b1;
                    end
                end else begin
                    if (d_vld) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                    if (accept && !a_vld) begin
                        a_q   <= new_x;
                        a_vld <= 1'b1;
                    end else if (accept) begin
                        r_q   <= new_x;
                        r_vld <= 1'b1;
                    end
                end
            end else if (accept && !a_vld) begin
                a_q   <= new_x;
                a_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_mtx_cmd_master.sv
// Directed bench for ahb_mtx_cmd_master: cycle-by-cycle slave responses with hand-computed expectations.
module tb_ahb_mtx_cmd_master;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [2:0]  cmd_size = 3'b010;
    logic        rsp_valid, rsp_err, busy, HWRITE;
    logic [31:0] rsp_rdata, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;
    logic [31:0] HRDATA = '0;

    int tests = 0;
    int errs  = 0;

    ahb_mtx_cmd_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    // inputs change 1ns after the edge, outputs are checked 1ns later
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [31:0] a, input logic w, input logic [31:0] wd);
        cmd_valid = v; cmd_addr = a; cmd_write = w; cmd_wdata = wd;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #2;
        tests++; if (HTRANS !== 2'b00) begin errs++; $display("FAIL reset_htrans got %b exp 00", HTRANS); end
        tests++; if (HADDR !== 32'h0 || HWDATA !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'b0) begin errs++; $display("FAIL reset_bus got addr %h wdata %h w %b sz %b exp zeros", HADDR, HWDATA, HWRITE, HSIZE); end
        tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || busy !== 1'b0) begin errs++; $display("FAIL reset_rsp got v %b e %b d %h busy %b exp 0", rsp_valid, rsp_err, rsp_rdata, busy); end
        tests++; if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin errs++; $display("FAIL const_ctrl got burst %b prot %b exp 000 0011", HBURST, HPROT); end
        HRESETn = 1'b1;
        tick();
        tests++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_read_zero_wait();
        set_cmd(1'b1, 32'h0000_1000, 1'b0, 32'h0);
        #1;
        tests++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rd_ready got %b exp 1", cmd_ready); end
        tick();
        set_cmd(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_1000 || HWRITE !== 1'b0) begin errs++; $display("FAIL rd_addr_phase got %b %h %b exp 10 00001000 0", HTRANS, HADDR, HWRITE); end
        tick();
        HRDATA = 32'hCAFE_F00D;
        #1;
        tests++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rd_early_rsp got %b exp 0", rsp_valid); end
        tick();
        HRDATA = 32'h0;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0) begin errs++; $display("FAIL rd_rsp got v %b d %h e %b exp 1 cafef00d 0", rsp_valid, rsp_rdata, rsp_err); end
        tick();
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rd_idle got v %b busy %b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        set_cmd(1'b1, 32'h20, 1'b1, 32'h1122_3344);
        tick();
        set_cmd(1'b1, 32'h24, 1'b0, 32'h0);
        #1;
        tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h20 || HWRITE !== 1'b1 || cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_wr_addr got %b %h %b rdy %b exp 10 20 1 1", HTRANS, HADDR, HWRITE, cmd_ready); end
        tick();
        set_cmd(1'b0, 32'h0, 1'b0, 32'h0);
        for (int w = 0; w < 2; w++) begin
            HREADY = 1'b0;
            #1;
            tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h24 || HWRITE !== 1'b0 || HWDATA !== 32'h1122_3344 || cmd_ready !== 1'b0) begin errs++; $display("FAIL b2b_wait%0d got %b %h %b %h rdy %b exp 10 24 0 11223344 0", w, HTRANS, HADDR, HWRITE, HWDATA, cmd_ready); end
            tick();
        end
        HREADY = 1'b1;
        #1;
        tests++; if (HWDATA !== 32'h1122_3344 || rsp_valid !== 1'b0) begin errs++; $display("FAIL b2b_wr_last got %h v %b exp 11223344 0", HWDATA, rsp_valid); end
        tick();
        HRDATA = 32'h5566_7788;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || HTRANS !== 2'b00) begin errs++; $display("FAIL b2b_wr_rsp got v %b e %b d %h tr %b exp 1 0 0 00", rsp_valid, rsp_err, rsp_rdata, HTRANS); end
        tick();
        HRDATA = 32'h0;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5566_7788 || rsp_err !== 1'b0) begin errs++; $display("FAIL b2b_rd_rsp got v %b d %h e %b exp 1 55667788 0", rsp_valid, rsp_rdata, rsp_err); end
        tick();
    endtask

    task automatic test_error();
        set_cmd(1'b1, 32'hDEAD_0000, 1'b0, 32'h0);
        tick();
        set_cmd(1'b1, 32'h40, 1'b1, 32'hA5A5_A5A5);
        tick();
        set_cmd(1'b0, 32'h0, 1'b0, 32'h0);
        HREADY = 1'b0; HRESP = 2'b01; HRDATA = 32'h0BAD_0BAD;
        #1;
        tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h40) begin errs++; $display("FAIL err_first got %b %h exp 10 40", HTRANS, HADDR); end
        tick();
        HREADY = 1'b1;
        #1;
        tests++; if (HTRANS !== 2'b00 || HADDR !== 32'h40 || HWRITE !== 1'b1) begin errs++; $display("FAIL err_second got %b %h %b exp 00 40 1", HTRANS, HADDR, HWRITE); end
        tick();
        HRESP = 2'b00; HRDATA = 32'h0;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL err_rsp got v %b e %b d %h exp 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
        tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h40) begin errs++; $display("FAIL err_reissue got %b %h exp 10 40", HTRANS, HADDR); end
        tick();
        #1;
        tests++; if (rsp_valid !== 1'b0 || HWDATA !== 32'hA5A5_A5A5) begin errs++; $display("FAIL err_wr_data got v %b wd %h exp 0 a5a5a5a5", rsp_valid, HWDATA); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errs++; $display("FAIL err_wr_rsp got v %b e %b exp 1 0", rsp_valid, rsp_err); end
        tick();
    endtask

    task automatic test_retry_pipelined();
        set_cmd(1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        set_cmd(1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        set_cmd(1'b1, 32'h300, 1'b0, 32'h0);
        HREADY = 1'b0; HRESP = 2'b10;
        #1;
        tests++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL rty_rdy1 got %b exp 0", cmd_ready); end
        tick();
        HREADY = 1'b1;
        #1;
        tests++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b0) begin errs++; $display("FAIL rty_second got tr %b rdy %b exp 00 0", HTRANS, cmd_ready); end
        tick();
        HRESP = 2'b00;
        #1;
        tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h100 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errs++; $display("FAIL rty_replay got %b %h rdy %b v %b exp 10 100 0 0", HTRANS, HADDR, cmd_ready, rsp_valid); end
        tick();
        HRDATA = 32'h1111_0100;
        #1;
        tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h200 || cmd_ready !== 1'b1) begin errs++; $display("FAIL rty_drain got %b %h rdy %b exp 10 200 1", HTRANS, HADDR, cmd_ready); end
        tick();
        set_cmd(1'b0, 32'h0, 1'b0, 32'h0);
        HRDATA = 32'h2222_0200;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1111_0100 || HADDR !== 32'h300) begin errs++; $display("FAIL rty_rsp1 got v %b d %h a %h exp 1 11110100 300", rsp_valid, rsp_rdata, HADDR); end
        tick();
        HRDATA = 32'h3333_0300;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2222_0200) begin errs++; $display("FAIL rty_rsp2 got v %b d %h exp 1 22220200", rsp_valid, rsp_rdata); end
        tick();
        HRDATA = 32'h0;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3333_0300 || rsp_err !== 1'b0) begin errs++; $display("FAIL rty_rsp3 got v %b d %h e %b exp 1 33330300 0", rsp_valid, rsp_rdata, rsp_err); end
        tick();
    endtask

    task automatic test_retry_exhaust();
        int phases = 0;
        int st = 0;
        bit got = 1'b0;
        logic err_seen = 1'b0;
        logic [31:0] d_seen = '0;
        set_cmd(1'b1, 32'h500, 1'b0, 32'h0);
        tick();
        set_cmd(1'b0, 32'h0, 1'b0, 32'h0);
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            case (st)
                1:       begin HREADY = 1'b0; HRESP = 2'b10; end
                2:       begin HREADY = 1'b1; HRESP = 2'b10; end
                default: begin HREADY = 1'b1; HRESP = 2'b00; end
            endcase
            #1;
            if (rsp_valid) begin got = 1'b1; err_seen = rsp_err; d_seen = rsp_rdata; end
            if (st == 1) st = 2;
            else if (HTRANS == 2'b10) begin phases++; st = 1; end
            else st = 0;
            tick();
        end
        HREADY = 1'b1; HRESP = 2'b00;
        tests++; if (!got) begin errs++; $display("FAIL exh_timeout got no rsp exp rsp within 200 cycles"); end
        tests++; if (phases != 16) begin errs++; $display("FAIL exh_phases got %0d exp 16", phases); end
        tests++; if (err_seen !== 1'b1 || d_seen !== 32'h0) begin errs++; $display("FAIL exh_rsp got e %b d %h exp 1 0", err_seen, d_seen); end
        #1;
        tests++; if (busy !== 1'b0) begin errs++; $display("FAIL exh_busy got %b exp 0", busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit saw_rsp = 1'b0;
        set_cmd(1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        set_cmd(1'b1, 32'h604, 1'b1, 32'h77);
        tick();
        set_cmd(1'b0, 32'h0, 1'b0, 32'h0);
        HREADY = 1'b0;
        #1;
        tests++; if (busy !== 1'b1 || HTRANS !== 2'b10) begin errs++; $display("FAIL rst_pre got busy %b tr %b exp 1 10", busy, HTRANS); end
        #1;
        HRESETn = 1'b0;
        #1;
        tests++; if (HTRANS !== 2'b00 || busy !== 1'b0 || rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_async got tr %b busy %b v %b exp 00 0 0", HTRANS, busy, rsp_valid); end
        HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid) saw_rsp = 1'b1;
        end
        #2;
        HRESETn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rsp_valid) saw_rsp = 1'b1;
        end
        tests++; if (saw_rsp) begin errs++; $display("FAIL rst_no_rsp got rsp_valid pulse exp none"); end
        tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || HTRANS !== 2'b00) begin errs++; $display("FAIL rst_release got rdy %b busy %b tr %b exp 1 0 00", cmd_ready, busy, HTRANS); end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_back_to_back();
        test_error();
        test_retry_pipelined();
        test_retry_exhaust();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
